inst_buffer: RTL and testbench

Dual-slot instruction buffer between fetch and decode. Each cycle it accepts zero, one or two fetched {pc, inst} pairs from the fetch stage, which is driven by the dual-PC generator. It presents the two oldest entries to dual-issue decode and retires zero, one or two per cycle as decode consumes them. It back-pressures the PC generator through `stall_o` and discards its entire contents on a pipeline flush.

---
 rtl/inst_buffer_pkg.sv | 17 +
 rtl/inst_buffer_if.sv | 34 +++
 rtl/inst_buffer_mem.sv | 32 +++
 rtl/inst_buffer.sv | 88 ++++++++
 tb/tb_inst_buffer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared widths, entry type and default depth for the fetch/decode instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstWidth     = 32;
    localparam int unsigned InstBufDepth  = 8;

    typedef logic [InstAddrWidth-1:0] inst_addr_t;
    typedef logic [InstWidth-1:0]     inst_t;
    typedef logic [31:0]              reg_t;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } inst_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic       flush;
    logic       in_valid_1;
    inst_addr_t in_pc_1;
    inst_t      in_inst_1;
    logic       in_valid_2;
    inst_addr_t in_pc_2;
    inst_t      in_inst_2;
    logic       stall_o;
    logic       issue_1;
    logic       issue_2;
    logic       out_valid_1;
    inst_addr_t out_pc_1;
    inst_t      out_inst_1;
    logic       out_valid_2;
    inst_addr_t out_pc_2;
    inst_t      out_inst_2;

    modport master (
        output flush, in_valid_1, in_pc_1, in_inst_1, in_valid_2, in_pc_2, in_inst_2,
        output issue_1, issue_2,
        input  stall_o, out_valid_1, out_pc_1, out_inst_1, out_valid_2, out_pc_2, out_inst_2
    );

    modport slave (
        input  flush, in_valid_1, in_pc_1, in_inst_1, in_valid_2, in_pc_2, in_inst_2,
        input  issue_1, issue_2,
        output stall_o, out_valid_1, out_pc_1, out_inst_1, out_valid_2, out_pc_2, out_inst_2
    );

endinterface

// File: rtl/inst_buffer_mem.sv
// DEPTH-entry {pc, inst} register array: two write ports, two asynchronous read ports, no reset.
module inst_buffer_mem
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = InstBufDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_1,
    input  logic [AW-1:0] waddr_1,
    input  inst_entry_t   wdata_1,
    input  logic          we_2,
    input  logic [AW-1:0] waddr_2,
    input  inst_entry_t   wdata_2,
    input  logic [AW-1:0] raddr_1,
    input  logic [AW-1:0] raddr_2,
    output inst_entry_t   rdata_1,
    output inst_entry_t   rdata_2
);

    inst_entry_t mem [DEPTH];

    // Write addresses are always consecutive, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (we_1) mem[waddr_1] <= wdata_1;
        if (we_2) mem[waddr_2] <= wdata_2;
    end

    assign rdata_1 = mem[raddr_1];
    assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_buffer.sv
// Dual-slot instruction buffer between fetch and dual-issue decode: up to two
// writes and two retirements per cycle, back-pressure via stall_o, flush discards all.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = InstBufDepth
) (
    input logic         clk,
    input logic         rst,
    inst_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [1:0]    wr;
    logic [1:0]    rd;
    inst_entry_t   rdata_1;
    inst_entry_t   rdata_2;
    logic          valid_1;
    logic          valid_2;

    assign bus.stall_o = (count > CW'(DEPTH - 2));

    always_comb begin
        wr = 2'd0;
        if (!bus.stall_o && !bus.flush && bus.in_valid_1) begin
            wr = bus.in_valid_2 ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        rd = 2'd0;
        if (bus.issue_1 && bus.issue_2 && (count >= CW'(2))) begin
            rd = 2'd2;
        end else if (bus.issue_1 && (count >= CW'(1))) begin
            rd = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rd);
            tail  <= tail + AW'(wr);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    inst_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_1    (wr != 2'd0),
        .waddr_1 (tail),
        .wdata_1 ('{pc: bus.in_pc_1, inst: bus.in_inst_1}),
        .we_2    (wr == 2'd2),
        .waddr_2 (tail + AW'(1)),
        .wdata_2 ('{pc: bus.in_pc_2, inst: bus.in_inst_2}),
        .raddr_1 (head),
        .raddr_2 (head + AW'(1)),
        .rdata_1 (rdata_1),
        .rdata_2 (rdata_2)
    );

    // Outputs come only from stored entries; empty slots read as zero.
    assign valid_1 = (count >= CW'(1));
    assign valid_2 = (count >= CW'(2));

    assign bus.out_valid_1 = valid_1;
    assign bus.out_pc_1    = valid_1 ? rdata_1.pc   : '0;
    assign bus.out_inst_1  = valid_1 ? rdata_1.inst : '0;
    assign bus.out_valid_2 = valid_2;
    assign bus.out_pc_2    = valid_2 ? rdata_2.pc   : '0;
    assign bus.out_inst_2  = valid_2 ? rdata_2.inst : '0;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed-vector bench for inst_buffer with hand-computed expected PCs and occupancy.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    localparam logic [31:0] B = 32'h1c00_0000;

    always #5 clk = ~clk;

    inst_buffer_if bus ();

    inst_buffer #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_5a5a;
    endfunction

    task automatic drive(input logic v1, input logic [31:0] pc1, input logic v2,
                         input logic [31:0] pc2, input logic i1, input logic i2,
                         input logic fl);
        bus.in_valid_1 = v1;
        bus.in_pc_1    = pc1;
        bus.in_inst_1  = inst_of(pc1);
        bus.in_valid_2 = v2;
        bus.in_pc_2    = pc2;
        bus.in_inst_2  = inst_of(pc2);
        bus.issue_1    = i1;
        bus.issue_2    = i2;
        bus.flush      = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // v=0 expects zeroed data; pc=0 is passed for invalid slots.
    task automatic expect_out(input string tag, input logic [3:0] cnt, input logic stall,
                              input logic v1, input logic [31:0] pc1,
                              input logic v2, input logic [31:0] pc2);
        check({tag, ".count"}, 64'(dut.count), 64'(cnt));
        check({tag, ".stall"}, 64'(bus.stall_o), 64'(stall));
        check({tag, ".v1"}, 64'(bus.out_valid_1), 64'(v1));
        check({tag, ".pc1"}, 64'(bus.out_pc_1), 64'(pc1));
        check({tag, ".inst1"}, 64'(bus.out_inst_1), v1 ? 64'(inst_of(pc1)) : 64'h0);
        check({tag, ".v2"}, 64'(bus.out_valid_2), 64'(v2));
        check({tag, ".pc2"}, 64'(bus.out_pc_2), 64'(pc2));
        check({tag, ".inst2"}, 64'(bus.out_inst_2), v2 ? 64'(inst_of(pc2)) : 64'h0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        expect_out("reset", 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;

        // Fill with four dual writes; stall appears only at count 8.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, B + 32'(8 * k), 1'b1, B + 32'(8 * k + 4), 1'b0, 1'b0, 1'b0);
            step();
            check("fill.count", 64'(dut.count), 64'(2 * (k + 1)));
            check("fill.stall", 64'(bus.stall_o), 64'(k == 3));
        end
        expect_out("full", 4'd8, 1'b1, 1'b1, B, 1'b1, B + 32'h4);
        drive(1'b1, B + 32'h40, 1'b1, B + 32'h44, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("drop", 4'd8, 1'b1, 1'b1, B, 1'b1, B + 32'h4);

        // Down to 6, then simultaneous dual write and dual issue.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("to6", 4'd6, 1'b0, 1'b1, B + 32'h8, 1'b1, B + 32'hc);
        drive(1'b1, B + 32'h20, 1'b1, B + 32'h24, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("rdwr", 4'd6, 1'b0, 1'b1, B + 32'h10, 1'b1, B + 32'h14);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("drain1", 4'd4, 1'b0, 1'b1, B + 32'h18, 1'b1, B + 32'h1c);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("drain2", 4'd2, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h24);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("drain3", 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // head=tail=2: single writes with issue_1 walk tail through 7 and wrap to 0.
        for (int j = 0; j < 7; j++) begin
            drive(1'b1, B + 32'(8 + 4 * j), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
            expect_out("wrap", 4'd1, 1'b0, 1'b1, B + 32'(8 + 4 * j), 1'b0, 32'h0);
        end
        drive(1'b1, B + 32'h24, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("wrap2", 4'd2, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h24);

        // in_valid_2 alone and issue_2 alone do nothing.
        drive(1'b0, 32'h0, 1'b1, B + 32'h90, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("lone2", 4'd2, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h24);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("iss1", 4'd1, 1'b0, 1'b1, B + 32'h24, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("over", 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Build count 5, then flush while writing and issuing.
        drive(1'b1, B + 32'h40, 1'b1, B + 32'h44, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, B + 32'h48, 1'b1, B + 32'h4c, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, B + 32'h50, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("five", 4'd5, 1'b0, 1'b1, B + 32'h40, 1'b1, B + 32'h44);
        drive(1'b1, B + 32'h60, 1'b1, B + 32'h64, 1'b1, 1'b1, 1'b1);
        step();
        expect_out("flush", 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Asynchronous reset mid-cycle with three entries, then resume.
        drive(1'b1, B + 32'h70, 1'b1, B + 32'h74, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, B + 32'h78, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("three", 4'd3, 1'b0, 1'b1, B + 32'h70, 1'b1, B + 32'h74);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expect_out("arst", 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        drive(1'b1, B + 32'h80, 1'b1, B + 32'h84, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("resume", 4'd2, 1'b0, 1'b1, B + 32'h80, 1'b1, B + 32'h84);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
